// File: rtl/ra_pkg.sv
// Shared constants, op/element encodings and sequencer states for the
// 64x72 register-array March C- self-test.
package ra_pkg;

    localparam int unsigned RA_ADR_W  = 6;
    localparam int unsigned RA_DAT_W  = 72;
    localparam int unsigned RA_WORDS  = 64;
    localparam int unsigned RA_ELEM_W = 3;

    typedef enum logic [1:0] {
        OP_W0 = 2'd0,
        OP_W1 = 2'd1,
        OP_R0 = 2'd2,
        OP_R1 = 2'd3
    } ra_op_e;

    typedef enum logic [RA_ELEM_W-1:0] {
        ELEM_M0 = 3'd0,
        ELEM_M1 = 3'd1,
        ELEM_M2 = 3'd2,
        ELEM_M3 = 3'd3,
        ELEM_M4 = 3'd4,
        ELEM_M5 = 3'd5
    } ra_elem_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Operation performed by an element; 'second' selects the write of a read-write pair.
    function automatic ra_op_e ra_elem_op(input logic [RA_ELEM_W-1:0] elem, input logic second);
        ra_op_e op;
        op = OP_R0;
        case (elem)
            ELEM_M0:          op = OP_W0;
            ELEM_M1, ELEM_M3: op = second ? OP_W1 : OP_R0;
            ELEM_M2, ELEM_M4: op = second ? OP_W0 : OP_R1;
            default:          op = OP_R0;
        endcase
        return op;
    endfunction

    function automatic logic ra_elem_down(input logic [RA_ELEM_W-1:0] elem);
        return (elem == ELEM_M3) || (elem == ELEM_M4);
    endfunction

    function automatic logic ra_elem_rw(input logic [RA_ELEM_W-1:0] elem);
        return (elem == ELEM_M1) || (elem == ELEM_M2) || (elem == ELEM_M3) || (elem == ELEM_M4);
    endfunction

    function automatic logic ra_op_is_rd(input ra_op_e op);
        return (op == OP_R0) || (op == OP_R1);
    endfunction

    function automatic logic ra_op_inv(input ra_op_e op);
        return (op == OP_W1) || (op == OP_R1);
    endfunction

endpackage

// File: rtl/ra_march_chk.sv
// Read-return check pipeline: carries {valid, addr, elem, expected} for RD_LAT
// cycles, compares both read ports at the tail and latches the first miscompare.
module ra_march_chk
    import ra_pkg::*;
#(
    parameter int unsigned RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clr,
    input  logic                 i_vld,
    input  logic [0:RA_ADR_W-1]  i_adr,
    input  logic [0:RA_ELEM_W-1] i_elem,
    input  logic [0:RA_DAT_W-1]  i_exp,
    input  logic [0:RA_DAT_W-1]  i_dat_0,
    input  logic [0:RA_DAT_W-1]  i_dat_1,
    output logic                 o_fail,
    output logic [0:RA_ADR_W-1]  o_fail_adr,
    output logic [0:RA_ELEM_W-1] o_fail_elem,
    output logic                 o_fail_port
);

    localparam int unsigned TAIL = RD_LAT - 1;

    logic                 r_vld  [RD_LAT];
    logic [0:RA_ADR_W-1]  r_adr  [RD_LAT];
    logic [0:RA_ELEM_W-1] r_elem [RD_LAT];
    logic [0:RA_DAT_W-1]  r_exp  [RD_LAT];

    logic                 r_fail;
    logic [0:RA_ADR_W-1]  r_fail_adr;
    logic [0:RA_ELEM_W-1] r_fail_elem;
    logic                 r_fail_port;

    logic w_mis_0;
    logic w_mis_1;

    assign w_mis_0 = r_vld[TAIL] && (i_dat_0 != r_exp[TAIL]);
    assign w_mis_1 = r_vld[TAIL] && (i_dat_1 != r_exp[TAIL]);

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_vld[i]  <= 1'b0;
                r_adr[i]  <= '0;
                r_elem[i] <= '0;
                r_exp[i]  <= '0;
            end
        end else begin
            r_vld[0]  <= i_vld;
            r_adr[0]  <= i_adr;
            r_elem[0] <= i_elem;
            r_exp[0]  <= i_exp;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_adr[i]  <= r_adr[i-1];
                r_elem[i] <= r_elem[i-1];
                r_exp[i]  <= r_exp[i-1];
            end
        end
    end

    // Only the first miscompare is kept; port 0 takes priority on a tie.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_fail      <= 1'b0;
            r_fail_adr  <= '0;
            r_fail_elem <= '0;
            r_fail_port <= 1'b0;
        end else if (!r_fail && (w_mis_0 || w_mis_1)) begin
            r_fail      <= 1'b1;
            r_fail_adr  <= r_adr[TAIL];
            r_fail_elem <= r_elem[TAIL];
            r_fail_port <= !w_mis_0;
        end
    end

    assign o_fail      = r_fail;
    assign o_fail_adr  = r_fail_adr;
    assign o_fail_elem = r_fail_elem;
    assign o_fail_port = r_fail_port;

endmodule

// File: rtl/ra_march.sv
// March C- sequencer for the 64x72 2R1W register array: drives the write port
// and both read ports, and hands read returns to the check pipeline.
module ra_march
    import ra_pkg::*;
#(
    parameter int unsigned RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [0:RA_DAT_W-1]  bkg,
    output logic                 wr_enb_0,
    output logic [0:RA_ADR_W-1]  wr_adr_0,
    output logic [0:RA_DAT_W-1]  wr_dat_0,
    output logic                 rd_enb_0,
    output logic [0:RA_ADR_W-1]  rd_adr_0,
    output logic                 rd_enb_1,
    output logic [0:RA_ADR_W-1]  rd_adr_1,
    input  logic [0:RA_DAT_W-1]  rd_dat_0,
    input  logic [0:RA_DAT_W-1]  rd_dat_1,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [0:RA_ADR_W-1]  fail_adr,
    output logic [0:RA_ELEM_W-1] fail_elem,
    output logic                 fail_port
);

    localparam int unsigned        DRN_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DRN_W-1:0]   DRN_LAST = DRN_W'(RD_LAT - 1);
    localparam logic [RA_ADR_W-1:0] CNT_LAST = RA_ADR_W'(RA_WORDS - 1);

    logic [1:0]           r_state;
    logic [RA_ELEM_W-1:0] r_elem;
    logic [RA_ADR_W-1:0]  r_cnt;
    logic                 r_second;
    logic                 r_gap;
    logic [DRN_W-1:0]     r_drn;
    logic [0:RA_DAT_W-1]  r_bkg;

    logic                 r_wr_enb;
    logic [0:RA_ADR_W-1]  r_wr_adr;
    logic [0:RA_DAT_W-1]  r_wr_dat;
    logic                 r_rd_enb;
    logic [0:RA_ADR_W-1]  r_rd_adr;
    logic [0:RA_ELEM_W-1] r_rd_elem;
    logic [0:RA_DAT_W-1]  r_rd_exp;
    logic                 r_busy;
    logic                 r_done;

    logic [1:0]           w_state;
    logic [RA_ELEM_W-1:0] w_elem;
    logic [RA_ADR_W-1:0]  w_cnt;
    logic                 w_second;
    logic                 w_gap;
    logic                 w_issue;
    logic                 w_start_ok;
    ra_op_e               w_op;
    logic [RA_ADR_W-1:0]  w_adr;
    logic [0:RA_DAT_W-1]  w_bkg;
    logic [0:RA_DAT_W-1]  w_dat;
    logic                 w_rd;
    logic                 w_wr;

    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Next-state describes the command that will be on the outputs next cycle.
    always_comb begin
        w_state  = r_state;
        w_elem   = r_elem;
        w_cnt    = r_cnt;
        w_second = r_second;
        w_gap    = r_gap;
        w_issue  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok) begin
                    w_state  = ST_RUN;
                    w_elem   = ELEM_M0;
                    w_cnt    = '0;
                    w_second = 1'b0;
                    w_gap    = 1'b0;
                    w_issue  = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_gap) begin
                    w_gap    = 1'b0;
                    w_second = 1'b0;
                    w_issue  = 1'b1;
                end else if (ra_elem_rw(r_elem) && !r_second) begin
                    w_second = 1'b1;
                    w_issue  = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt    = '0;
                    w_second = 1'b0;
                    if (r_elem == ELEM_M5) begin
                        w_state = ST_DRAIN;
                    end else begin
                        w_gap  = 1'b1;
                        w_elem = r_elem + 3'd1;
                    end
                end else begin
                    w_cnt    = r_cnt + 6'd1;
                    w_second = 1'b0;
                    w_issue  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_drn == DRN_LAST) begin
                    w_state = ST_DONE;
                end
            end
            default: w_state = ST_IDLE;
        endcase

        w_op  = ra_elem_op(w_elem, w_second);
        // Down elements walk the same counter with the address bits inverted.
        w_adr = w_cnt ^ {RA_ADR_W{ra_elem_down(w_elem)}};
        w_bkg = w_start_ok ? bkg : r_bkg;
        w_dat = w_bkg ^ {RA_DAT_W{ra_op_inv(w_op)}};
        w_rd  = w_issue && ra_op_is_rd(w_op);
        w_wr  = w_issue && !ra_op_is_rd(w_op);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_elem    <= '0;
            r_cnt     <= '0;
            r_second  <= 1'b0;
            r_gap     <= 1'b0;
            r_drn     <= '0;
            r_bkg     <= '0;
            r_wr_enb  <= 1'b0;
            r_wr_adr  <= '0;
            r_wr_dat  <= '0;
            r_rd_enb  <= 1'b0;
            r_rd_adr  <= '0;
            r_rd_elem <= '0;
            r_rd_exp  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_elem    <= w_elem;
            r_cnt     <= w_cnt;
            r_second  <= w_second;
            r_gap     <= w_gap;
            r_drn     <= (r_state == ST_DRAIN) ? r_drn + DRN_W'(1) : '0;
            r_bkg     <= w_bkg;
            r_wr_enb  <= w_wr;
            r_wr_adr  <= w_wr ? w_adr : '0;
            r_wr_dat  <= w_wr ? w_dat : '0;
            r_rd_enb  <= w_rd;
            r_rd_adr  <= w_rd ? w_adr : '0;
            r_rd_elem <= w_rd ? w_elem : '0;
            r_rd_exp  <= w_rd ? w_dat : '0;
            r_busy    <= (w_state == ST_RUN) || (w_state == ST_DRAIN);
            r_done    <= (w_state == ST_DONE);
        end
    end

    ra_march_chk #(
        .RD_LAT (RD_LAT)
    ) u_chk (
        .clk         (clk),
        .reset       (reset),
        .i_clr       (w_start_ok),
        .i_vld       (r_rd_enb),
        .i_adr       (r_rd_adr),
        .i_elem      (r_rd_elem),
        .i_exp       (r_rd_exp),
        .i_dat_0     (rd_dat_0),
        .i_dat_1     (rd_dat_1),
        .o_fail      (fail),
        .o_fail_adr  (fail_adr),
        .o_fail_elem (fail_elem),
        .o_fail_port (fail_port)
    );

    assign wr_enb_0 = r_wr_enb;
    assign wr_adr_0 = r_wr_adr;
    assign wr_dat_0 = r_wr_dat;
    assign rd_enb_0 = r_rd_enb;
    assign rd_adr_0 = r_rd_adr;
    assign rd_enb_1 = r_rd_enb;
    assign rd_adr_1 = r_rd_adr;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_ra_march.sv
// Bench for ra_march: behavioural 2R1W array with injectable read faults and a
// March C- command-trace reference model built directly from the element table.
module tb_ra_march;

    localparam int unsigned RD_LAT   = 2;
    localparam int          CMD_CYC  = 645;
    localparam int          DONE_CYC = 646 + RD_LAT;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [5:0]  adr;
        logic [2:0]  elem;
        logic [0:71] dat;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [0:71] bkg;
    logic        wr_enb_0;
    logic [0:5]  wr_adr_0;
    logic [0:71] wr_dat_0;
    logic        rd_enb_0;
    logic [0:5]  rd_adr_0;
    logic        rd_enb_1;
    logic [0:5]  rd_adr_1;
    logic [0:71] rd_dat_0;
    logic [0:71] rd_dat_1;
    logic        busy;
    logic        done;
    logic        fail;
    logic [0:5]  fail_adr;
    logic [0:2]  fail_elem;
    logic        fail_port;
    logic [105:0] all_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ra_march #(
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bkg       (bkg),
        .wr_enb_0  (wr_enb_0),
        .wr_adr_0  (wr_adr_0),
        .wr_dat_0  (wr_dat_0),
        .rd_enb_0  (rd_enb_0),
        .rd_adr_0  (rd_adr_0),
        .rd_enb_1  (rd_enb_1),
        .rd_adr_1  (rd_adr_1),
        .rd_dat_0  (rd_dat_0),
        .rd_dat_1  (rd_dat_1),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_adr  (fail_adr),
        .fail_elem (fail_elem),
        .fail_port (fail_port)
    );

    assign all_out = {wr_enb_0, wr_adr_0, wr_dat_0, rd_enb_0, rd_adr_0, rd_enb_1, rd_adr_1,
                      busy, done, fail, fail_adr, fail_elem, fail_port};

    // Read-path stuck-bit faults, one per port.
    logic       f0_en, f1_en, f0_val, f1_val;
    logic [5:0] f0_adr, f1_adr;
    int         f0_bit, f1_bit;

    function automatic logic [0:71] apply_fault(input logic [0:71] d, input logic [5:0] a,
                                                input logic en, input logic [5:0] fa,
                                                input int fb, input logic fv);
        logic [0:71] r;
        r = d;
        if (en && (a == fa)) r[fb] = fv;
        return r;
    endfunction

    logic [0:71] mem [64];
    logic [0:71] p0 [RD_LAT];
    logic [0:71] p1 [RD_LAT];

    always @(posedge clk) begin
        if (wr_enb_0) mem[wr_adr_0] <= wr_dat_0;
        p0[0] <= apply_fault(mem[rd_adr_0], rd_adr_0, f0_en, f0_adr, f0_bit, f0_val);
        p1[0] <= apply_fault(mem[rd_adr_1], rd_adr_1, f1_en, f1_adr, f1_bit, f1_val);
        for (int i = 1; i < int'(RD_LAT); i++) begin
            p0[i] <= p0[i-1];
            p1[i] <= p1[i-1];
        end
    end

    assign rd_dat_0 = p0[RD_LAT-1];
    assign rd_dat_1 = p1[RD_LAT-1];

    // Reference model state.
    cmd_t       trace [$];
    logic       exp_fail, exp_port;
    logic [5:0] exp_adr;
    logic [2:0] exp_elem;
    int         exp_fail_cyc;

    // Observations from the last run.
    int          obs_trace_bad, obs_first_bad, obs_wr_cnt, obs_rd_cnt;
    int          obs_done_cyc, obs_busy_fall, obs_fail_cyc;
    logic [11:0] obs_clr;
    logic [0:71] obs_wr_c1, obs_wr_c67;

    task automatic push_cmd(input logic wr, input logic rd, input int a, input int e,
                            input logic [0:71] d);
        cmd_t c;
        c.wr   = wr;
        c.rd   = rd;
        c.adr  = 6'(a);
        c.elem = 3'(e);
        c.dat  = d;
        trace.push_back(c);
    endtask

    task automatic build_trace(input logic [0:71] b);
        int a;
        trace.delete();
        for (int e = 0; e < 6; e++) begin
            if (e != 0) push_cmd(1'b0, 1'b0, 0, e, '0);
            for (int i = 0; i < 64; i++) begin
                a = (e == 3 || e == 4) ? 63 - i : i;
                case (e)
                    0: push_cmd(1'b1, 1'b0, a, e, b);
                    1, 3: begin
                        push_cmd(1'b0, 1'b1, a, e, b);
                        push_cmd(1'b1, 1'b0, a, e, ~b);
                    end
                    2, 4: begin
                        push_cmd(1'b0, 1'b1, a, e, ~b);
                        push_cmd(1'b1, 1'b0, a, e, b);
                    end
                    default: push_cmd(1'b0, 1'b1, a, e, b);
                endcase
            end
        end
    endtask

    task automatic compute_expect();
        logic [0:71] mm [64];
        logic [0:71] r0, r1;
        exp_fail     = 1'b0;
        exp_port     = 1'b0;
        exp_adr      = '0;
        exp_elem     = '0;
        exp_fail_cyc = -1;
        for (int i = 0; i < 64; i++) mm[i] = '0;
        for (int i = 0; i < trace.size(); i++) begin
            if (trace[i].wr) mm[trace[i].adr] = trace[i].dat;
            if (trace[i].rd && !exp_fail) begin
                r0 = apply_fault(mm[trace[i].adr], trace[i].adr, f0_en, f0_adr, f0_bit, f0_val);
                r1 = apply_fault(mm[trace[i].adr], trace[i].adr, f1_en, f1_adr, f1_bit, f1_val);
                if (r0 !== trace[i].dat || r1 !== trace[i].dat) begin
                    exp_fail     = 1'b1;
                    exp_port     = (r0 === trace[i].dat);
                    exp_adr      = trace[i].adr;
                    exp_elem     = trace[i].elem;
                    exp_fail_cyc = i + 1 + RD_LAT + 1;
                end
            end
        end
    endtask

    task automatic clear_faults();
        f0_en = 1'b0; f0_adr = '0; f0_bit = 0; f0_val = 1'b0;
        f1_en = 1'b0; f1_adr = '0; f1_bit = 0; f1_val = 1'b0;
    endtask

    // Starts a run (caller is #1 after a posedge) and records what the DUT did.
    task automatic run_march(input logic [0:71] b, input int repulse);
        cmd_t e;
        logic bad;
        build_trace(b);
        compute_expect();
        obs_trace_bad = 0; obs_first_bad = -1; obs_wr_cnt = 0; obs_rd_cnt = 0;
        obs_done_cyc  = -1; obs_busy_fall = -1; obs_fail_cyc = -1;
        bkg   = b;
        start = 1'b1;
        for (int c = 1; c <= DONE_CYC + 20; c++) begin
            @(posedge clk);
            #1;
            start = (c == repulse);
            bkg   = ~b;
            if (c == 1) obs_clr = {done, fail, fail_adr, fail_elem, fail_port};
            if (c == 1) obs_wr_c1 = wr_dat_0;
            if (c == 67) obs_wr_c67 = wr_dat_0;
            if (c <= CMD_CYC) begin
                e = trace[c-1];
            end else begin
                e.wr = 1'b0; e.rd = 1'b0; e.adr = '0; e.elem = '0; e.dat = '0;
            end
            bad = (wr_enb_0 !== e.wr) || (rd_enb_0 !== e.rd) || (rd_enb_1 !== e.rd);
            if (e.wr) bad = bad || (wr_adr_0 !== e.adr) || (wr_dat_0 !== e.dat);
            if (e.rd) bad = bad || (rd_adr_0 !== e.adr) || (rd_adr_1 !== e.adr);
            if (bad) begin
                obs_trace_bad++;
                if (obs_first_bad < 0) obs_first_bad = c;
            end
            if (wr_enb_0) obs_wr_cnt++;
            if (rd_enb_0) obs_rd_cnt++;
            if (fail && obs_fail_cyc < 0) obs_fail_cyc = c;
            if (!busy && obs_busy_fall < 0) obs_busy_fall = c;
            if (done && obs_done_cyc < 0) obs_done_cyc = c;
            if (obs_done_cyc >= 0) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", all_out);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL idle_outputs: got %h required 0", all_out);
        end
    endtask

    task automatic test_clean();
        clear_faults();
        run_march('0, -1);
        checks++;
        if (obs_trace_bad !== 0) begin
            errors++;
            $display("FAIL clean_trace: %0d bad cycles (first %0d) required 0",
                     obs_trace_bad, obs_first_bad);
        end
        checks++;
        if (obs_done_cyc !== DONE_CYC) begin
            errors++;
            $display("FAIL clean_done_cycle: got %0d required %0d", obs_done_cyc, DONE_CYC);
        end
        checks++;
        if (obs_busy_fall !== DONE_CYC) begin
            errors++;
            $display("FAIL clean_busy_fall: got %0d required %0d", obs_busy_fall, DONE_CYC);
        end
        checks++;
        if (obs_wr_cnt !== 320 || obs_rd_cnt !== 320) begin
            errors++;
            $display("FAIL clean_op_counts: got wr %0d rd %0d required 320/320",
                     obs_wr_cnt, obs_rd_cnt);
        end
        checks++;
        if (fail !== 1'b0) begin
            errors++;
            $display("FAIL clean_fail: got %b required 0", fail);
        end
    endtask

    // Shared by all fault scenarios: compares the captured fields against the model.
    task automatic test_fault_case(input string name, input logic [0:71] b);
        run_march(b, -1);
        checks++;
        if (obs_trace_bad !== 0) begin
            errors++;
            $display("FAIL %s_trace: %0d bad cycles (first %0d) required 0",
                     name, obs_trace_bad, obs_first_bad);
        end
        checks++;
        if (obs_done_cyc !== DONE_CYC) begin
            errors++;
            $display("FAIL %s_done_cycle: got %0d required %0d", name, obs_done_cyc, DONE_CYC);
        end
        checks++;
        if ({fail, fail_adr, fail_elem, fail_port} !== {exp_fail, exp_adr, exp_elem, exp_port})
        begin
            errors++;
            $display("FAIL %s_capture: got fail %b adr %h elem %0d port %b required %b %h %0d %b",
                     name, fail, fail_adr, fail_elem, fail_port,
                     exp_fail, exp_adr, exp_elem, exp_port);
        end
        checks++;
        if (obs_fail_cyc !== exp_fail_cyc) begin
            errors++;
            $display("FAIL %s_fail_cycle: got %0d required %0d", name, obs_fail_cyc, exp_fail_cyc);
        end
    endtask

    task automatic test_fault_p0();
        clear_faults();
        f0_en = 1'b1; f0_adr = 6'h2A; f0_bit = 5; f0_val = 1'b1;
        test_fault_case("p0_bit5", '0);
        checks++;
        if ({fail, fail_adr, fail_elem, fail_port} !== {1'b1, 6'h2A, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL p0_bit5_fixed: got %b %h %0d %b required 1 2a 1 0",
                     fail, fail_adr, fail_elem, fail_port);
        end
    endtask

    task automatic test_back_to_back();
        clear_faults();
        run_march('0, -1);
        checks++;
        if (obs_clr !== '0) begin
            errors++;
            $display("FAIL b2b_clear: got %h required 0", obs_clr);
        end
        checks++;
        if (obs_done_cyc !== DONE_CYC || fail !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rerun: got done %0d fail %b required %0d 0",
                     obs_done_cyc, fail, DONE_CYC);
        end
    endtask

    task automatic test_fault_p1();
        clear_faults();
        f1_en = 1'b1; f1_adr = 6'h00; f1_bit = 71; f1_val = 1'b0;
        test_fault_case("p1_bit71", '0);
        checks++;
        if ({fail, fail_adr, fail_elem, fail_port} !== {1'b1, 6'h00, 3'd2, 1'b1}) begin
            errors++;
            $display("FAIL p1_bit71_fixed: got %b %h %0d %b required 1 00 2 1",
                     fail, fail_adr, fail_elem, fail_port);
        end
    endtask

    task automatic test_repulse();
        clear_faults();
        run_march('0, 100);
        checks++;
        if (obs_done_cyc !== DONE_CYC || obs_trace_bad !== 0) begin
            errors++;
            $display("FAIL repulse: got done %0d bad %0d required %0d 0",
                     obs_done_cyc, obs_trace_bad, DONE_CYC);
        end
    endtask

    task automatic test_pattern();
        logic [0:71] p55;
        logic [0:71] paa;
        p55 = 72'h555555555555555555;
        paa = 72'hAAAAAAAAAAAAAAAAAA;
        clear_faults();
        run_march(p55, -1);
        checks++;
        if (obs_wr_c1 !== p55 || obs_wr_c67 !== paa) begin
            errors++;
            $display("FAIL pattern_wdata: got %h %h required %h %h",
                     obs_wr_c1, obs_wr_c67, p55, paa);
        end
        checks++;
        if (obs_trace_bad !== 0 || fail !== 1'b0) begin
            errors++;
            $display("FAIL pattern_run: got bad %0d fail %b required 0 0", obs_trace_bad, fail);
        end
    endtask

    task automatic test_both_ports();
        clear_faults();
        f0_en = 1'b1; f0_adr = 6'h05; f0_bit = 10; f0_val = 1'b1;
        f1_en = 1'b1; f1_adr = 6'h05; f1_bit = 10; f1_val = 1'b1;
        test_fault_case("both_ports", '0);
    endtask

    task automatic test_random();
        logic [95:0] t;
        logic [0:71] b;
        for (int n = 0; n < 3; n++) begin
            clear_faults();
            t = {$urandom, $urandom, $urandom};
            b = t[71:0];
            if ($urandom_range(0, 1) == 0) begin
                f0_en = 1'b1; f0_adr = 6'($urandom_range(0, 63));
                f0_bit = $urandom_range(0, 71); f0_val = 1'($urandom_range(0, 1));
            end else begin
                f1_en = 1'b1; f1_adr = 6'($urandom_range(0, 63));
                f1_bit = $urandom_range(0, 71); f1_val = 1'($urandom_range(0, 1));
            end
            test_fault_case("random", b);
        end
    endtask

    task automatic test_reset_midrun();
        logic fail_seen;
        int   late;
        clear_faults();
        f0_en = 1'b1; f0_adr = 6'h2A; f0_bit = 5; f0_val = 1'b1;
        fail_seen = 1'b0;
        late      = 0;
        bkg   = '0;
        start = 1'b1;
        for (int c = 1; c <= 301; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (fail) fail_seen = 1'b1;
            if (c == 300) reset = 1'b1;
        end
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: got %h required 0", all_out);
        end
        checks++;
        if (fail_seen !== 1'b1) begin
            errors++;
            $display("FAIL midrun_fail_before_reset: got %b required 1", fail_seen);
        end
        reset = 1'b0;
        for (int c = 0; c < 700; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) late++;
        end
        checks++;
        if (late !== 0) begin
            errors++;
            $display("FAIL midrun_no_done: got %0d busy/done cycles required 0", late);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bkg   = '0;
        clear_faults();
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_clean();
        test_fault_p0();
        test_back_to_back();
        test_fault_p1();
        test_repulse();
        test_pattern();
        test_both_ports();
        test_random();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ra_march.md
# ra_march

March C- self-test sequencer for the 64x72 2R1W register array. It sits directly upstream of the array, in front of the BIST mux, and drives the array's write port and both read ports with a deterministic March C- sequence. Both read ports return data that is compared in a fixed-latency check pipeline. The first miscompare is latched for status readout.

## Interface
Parameters:
- `RD_LAT`, default 2: cycles from a registered `rd_enb_*` output to valid `rd_dat_*` input.

Ports:
- `clk`  in  1  array clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; honoured only in IDLE or DONE.
- `bkg`  in  [0:71]  data background, sampled when `start` is accepted. "0" = `bkg`, "1" = `~bkg`.
- `wr_enb_0`  out  1  array write enable.
- `wr_adr_0`  out  [0:5]  array write address.
- `wr_dat_0`  out  [0:71]  array write data.
- `rd_enb_0`  out  1  array read port 0 enable.
- `rd_adr_0`  out  [0:5]  array read port 0 address.
- `rd_enb_1`  out  1  array read port 1 enable.
- `rd_adr_1`  out  [0:5]  array read port 1 address.
- `rd_dat_0`  in  [0:71]  array read port 0 data.
- `rd_dat_1`  in  [0:71]  array read port 1 data.
- `busy`  out  1  in RUN or DRAIN.
- `done`  out  1  sticky until next accepted `start` or `reset`.
- `fail`  out  1  sticky, first miscompare.
- `fail_adr`  out  [0:5]  address of first miscompare.
- `fail_elem`  out  [0:2]  march element (0-5) of first miscompare.
- `fail_port`  out  1  read port of first miscompare; port 0 wins if both fail in the same cycle.

## Operation
- States:
  - IDLE: `start` -> RUN.
  - RUN: last command issued -> DRAIN.
  - DRAIN: RD_LAT cycles -> DONE.
  - DONE: `start` -> RUN.
- Elements, all over 64 addresses:
  - M0 up (w0)
  - M1 up (r0, w1)
  - M2 up (r1, w0)
  - M3 down (r0, w1)
  - M4 down (r1, w0)
  - M5 up (r0)
- Up order is 0..63; down order is 63..0. The address counter wraps 63->0 (up) or 0->63 (down) at element end.
- Read operation: one cycle with `rd_enb_0` = `rd_enb_1` = 1 and `rd_adr_0` = `rd_adr_1` = current address. Write operation: one cycle with `wr_enb_0` = 1. Read and write are never issued in the same cycle.
- Read-write elements use 2 cycles per address: read, then write.
- One idle gap cycle, with all enables 0, is inserted between consecutive elements. This guarantees write-to-read separation at element boundaries, e.g. M2 writes addr 63 last and M3 reads addr 63 first.
- Check pipeline: depth-RD_LAT shift register carrying {valid, addr, elem, expected}. At the tail, compare `rd_dat_0` and `rd_dat_1` against expected. On the first mismatch since `start`, set `fail` and capture `fail_adr`, `fail_elem` and `fail_port`. Later mismatches are ignored.
- Accepted `start`:
  - clears `done`, `fail`, `fail_adr`, `fail_elem`, `fail_port` and the check pipeline;
  - latches `bkg`.
- `start` while `busy` is ignored.
- `reset`, including mid-run, returns to IDLE next cycle; all outputs go to 0 and the pipeline is flushed.

## Timing
- All outputs are registered. Every output resets to 0.
- `start` sampled at cycle 0 -> first command (M0 w0, addr 0) at cycle 1; `busy` = 1 from cycle 1.
- Command cycles: 64 + 4*128 + 64 + 5 gaps = 645. The last command (M5 r0, addr 63) is issued at cycle 645.
- The read issued at cycle t is compared at cycle t+RD_LAT. The `fail` flag and fields update at cycle t+RD_LAT+1.
- `busy` falls and `done` rises at cycle 646+RD_LAT.
- `start` asserted the same cycle that `done` is high: accepted; `done` clears next cycle.

## Structure
- Shared `ra_pkg`:
  - constants `RA_ADR_W=6`, `RA_DAT_W=72`, `RA_WORDS=64`;
  - march element enum and op encoding (W0, W1, R0, R1);
  - state enum.
- Sub-module `ra_march_chk`: RD_LAT pipeline, comparators, first-fail capture. The sequencer FSM and counters stay in `ra_march`.

## Test plan
- Fault-free behavioural array, RD_LAT=2, `bkg`=0 -> `done` at cycle 648, `fail`=0, exactly 320 writes and 320 reads observed.
- Array model forces `rd_dat_0` bit 5 = 1 at addr 0x2A -> `fail`=1, `fail_adr`=0x2A, `fail_elem`=1, `fail_port`=0; `done` still at 648.
- Fault on port 1 only, bit 71 stuck-0 at addr 0x00 -> `fail_elem`=2, `fail_adr`=0x00, `fail_port`=1.
- `start` re-pulsed at cycle 100 -> ignored; `done` at 648. `start` pulsed again after `done` -> flags cleared, second run completes at relative cycle 648.
- `reset` at cycle 300 -> cycle 301 all outputs 0, IDLE; no `done` without a new `start`.
- `bkg`=0x55..55 (alternating bits) with a write-data monitor -> M0 writes 0x55..55, M1 writes 0xAA..AA; no fail.
